div_result_stage: RTL and testbench

Multi-cycle sequencing stage wrapped around the combinational 32-bit restoring divider in the ALU datapath. It latches the dividend and divisor and holds them stable on the divider inputs for a programmable settle window. It then captures the divider's 64-bit {remainder, quotient} result into HI/LO registers and streams it to the bus as two handshaked beats. Divide-by-zero is detected up front and bypasses the settle window.

---
 rtl/div_result_stage_if.sv | 29 ++
 rtl/div_result_stage.sv | 103 ++++++++++
 tb/tb_div_result_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/div_result_stage_if.sv
// Bundle of the operand, divider-result and output-beat signals for the divide sequencing stage.
interface div_result_stage_if;
   logic        start;
   logic [31:0] ra_in;
   logic [31:0] rb_in;
   logic [31:0] div_ra;
   logic [31:0] div_rb;
   logic [63:0] rz_in;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic [31:0] bus_out;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        div_zero;

   // Requester / divider / consumer side
   modport master (
      output start, ra_in, rb_in, rz_in, out_ready,
      input  div_ra, div_rb, busy, out_valid, out_last, bus_out, hi_out, lo_out, div_zero
   );

   // Sequencing stage side
   modport slave (
      input  start, ra_in, rb_in, rz_in, out_ready,
      output div_ra, div_rb, busy, out_valid, out_last, bus_out, hi_out, lo_out, div_zero
   );
endinterface

// File: rtl/div_result_stage.sv
// Holds operands on the combinational divider for a settle window, captures {rem, quo}
// into HI/LO and streams LO then HI as two handshaked beats; zero divisors skip the wait.
module div_result_stage #(
   parameter int unsigned WAIT_CYCLES = 4
) (
   input logic              clk,
   input logic              clr,
   div_result_stage_if.slave bus
);
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {IDLE, SETTLE, SEND_LO, SEND_HI} state_t;

   state_t              state, state_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic [DATA_W-1:0]   ra_q, ra_nx;
   logic [DATA_W-1:0]   rb_q, rb_nx;
   logic [DATA_W-1:0]   hi_q, hi_nx;
   logic [DATA_W-1:0]   lo_q, lo_nx;
   logic                zero_q, zero_nx;
   logic [DATA_W-1:0]   bus_mux;

   always_ff @(posedge clk) begin
      if (!clr) begin
         state  <= IDLE;
         cnt    <= '0;
         ra_q   <= '0;
         rb_q   <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         zero_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         ra_q   <= ra_nx;
         rb_q   <= rb_nx;
         hi_q   <= hi_nx;
         lo_q   <= lo_nx;
         zero_q <= zero_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ra_nx    = ra_q;
      rb_nx    = rb_q;
      hi_nx    = hi_q;
      lo_nx    = lo_q;
      zero_nx  = zero_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               ra_nx = bus.ra_in;
               rb_nx = bus.rb_in;
               if (bus.rb_in == DATA_W'(0)) begin
                  // Divide-by-zero result is fixed, so there is nothing to wait for
                  lo_nx    = '1;
                  hi_nx    = bus.ra_in;
                  zero_nx  = 1'b1;
                  state_nx = SEND_LO;
               end else begin
                  zero_nx  = 1'b0;
                  cnt_nx   = CNT_W'(WAIT_CYCLES);
                  state_nx = SETTLE;
               end
            end
         end
         SETTLE: begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               hi_nx    = bus.rz_in[63:32];
               lo_nx    = bus.rz_in[31:0];
               state_nx = SEND_LO;
            end
         end
         SEND_LO: if (bus.out_ready) state_nx = SEND_HI;
         SEND_HI: if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Beat data is decoded from registered state only; no path from out_ready
   always_comb begin
      bus_mux = '0;
      case (state)
         SEND_LO: bus_mux = lo_q;
         SEND_HI: bus_mux = hi_q;
         default: bus_mux = '0;
      endcase
   end

   assign bus.div_ra    = ra_q;
   assign bus.div_rb    = rb_q;
   assign bus.hi_out    = hi_q;
   assign bus.lo_out    = lo_q;
   assign bus.div_zero  = zero_q;
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == SEND_LO) || (state == SEND_HI);
   assign bus.out_last  = (state == SEND_HI);
   assign bus.bus_out   = bus_mux;
endmodule

// File: tb/tb_div_result_stage.sv
// Directed bench for div_result_stage with a behavioural restoring divider on rz_in.
module tb_div_result_stage;
   logic clk = 1'b0;
   logic clr = 1'b0;
   int   checks = 0;
   int   failures = 0;

   div_result_stage_if dif();

   div_result_stage #(.WAIT_CYCLES(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (dif)
   );

   always #5 clk = ~clk;

   // Divider model: signed quotient, remainder of |RA| by RB
   function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mag, q, r;
      if (b == 32'd0) return 64'd0;
      mag = a[31] ? (~a + 32'd1) : a;
      q   = mag / b;
      r   = mag % b;
      if (a[31]) q = ~q + 32'd1;
      return {r, q};
   endfunction

   assign dif.rz_in = divide(dif.div_ra, dif.div_rb);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] a, input logic [31:0] b);
      dif.start = 1'b1;
      dif.ra_in = a;
      dif.rb_in = b;
      tick();
      dif.start = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b0;
      tick();
      tick();
      clr = 1'b1;
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", dif.busy); end
      checks++; if (dif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dif.out_valid); end
      checks++; if (dif.bus_out !== 32'd0) begin failures++; $display("FAIL reset_bus got=%h exp=0", dif.bus_out); end
      checks++; if ({dif.hi_out, dif.lo_out} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", {dif.hi_out, dif.lo_out}); end
      checks++; if ({dif.div_ra, dif.div_rb} !== 64'd0) begin failures++; $display("FAIL reset_ops got=%h exp=0", {dif.div_ra, dif.div_rb}); end
      checks++; if (dif.div_zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", dif.div_zero); end
   endtask

   task automatic test_normal();
      dif.out_ready = 1'b1;
      do_start(32'd100, 32'd7);
      checks++; if (dif.busy !== 1'b1) begin failures++; $display("FAIL norm_busy got=%b exp=1", dif.busy); end
      checks++; if ({dif.div_ra, dif.div_rb} !== {32'd100, 32'd7}) begin failures++; $display("FAIL norm_ops got=%h exp=%h", {dif.div_ra, dif.div_rb}, {32'd100, 32'd7}); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (dif.out_valid !== 1'b0) begin failures++; $display("FAIL norm_early_valid e%0d got=%b exp=0", i, dif.out_valid); end
      end
      tick();
      checks++; if (dif.out_valid !== 1'b1) begin failures++; $display("FAIL norm_valid got=%b exp=1", dif.out_valid); end
      checks++; if (dif.bus_out !== 32'd14) begin failures++; $display("FAIL norm_beat0 got=%h exp=%h", dif.bus_out, 32'd14); end
      checks++; if (dif.out_last !== 1'b0) begin failures++; $display("FAIL norm_last0 got=%b exp=0", dif.out_last); end
      checks++; if ({dif.hi_out, dif.lo_out} !== {32'd2, 32'd14}) begin failures++; $display("FAIL norm_hilo got=%h exp=%h", {dif.hi_out, dif.lo_out}, {32'd2, 32'd14}); end
      tick();
      checks++; if (dif.bus_out !== 32'd2) begin failures++; $display("FAIL norm_beat1 got=%h exp=2", dif.bus_out); end
      checks++; if (dif.out_last !== 1'b1) begin failures++; $display("FAIL norm_last1 got=%b exp=1", dif.out_last); end
      tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL norm_done got=%b exp=0", dif.busy); end
      checks++; if (dif.out_valid !== 1'b0) begin failures++; $display("FAIL norm_valid_off got=%b exp=0", dif.out_valid); end
      checks++; if (dif.bus_out !== 32'd0) begin failures++; $display("FAIL norm_bus_off got=%h exp=0", dif.bus_out); end
      checks++; if (dif.div_zero !== 1'b0) begin failures++; $display("FAIL norm_zero got=%b exp=0", dif.div_zero); end
   endtask

   task automatic test_negative();
      dif.out_ready = 1'b1;
      do_start(32'hFFFF_FF9C, 32'd7);
      repeat (4) tick();
      checks++; if (dif.bus_out !== 32'hFFFF_FFF2) begin failures++; $display("FAIL neg_beat0 got=%h exp=fffffff2", dif.bus_out); end
      tick();
      checks++; if (dif.bus_out !== 32'd2) begin failures++; $display("FAIL neg_beat1 got=%h exp=2", dif.bus_out); end
      tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL neg_done got=%b exp=0", dif.busy); end
   endtask

   task automatic test_zero_divisor();
      dif.out_ready = 1'b0;
      do_start(32'd5, 32'd0);
      tick();
      checks++; if (dif.out_valid !== 1'b1) begin failures++; $display("FAIL zero_valid got=%b exp=1", dif.out_valid); end
      checks++; if (dif.bus_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL zero_beat0 got=%h exp=ffffffff", dif.bus_out); end
      checks++; if (dif.div_zero !== 1'b1) begin failures++; $display("FAIL zero_flag got=%b exp=1", dif.div_zero); end
      checks++; if (dif.hi_out !== 32'd5) begin failures++; $display("FAIL zero_hi got=%h exp=5", dif.hi_out); end
      dif.out_ready = 1'b1;
      tick();
      checks++; if ({dif.out_last, dif.bus_out} !== {1'b1, 32'd5}) begin failures++; $display("FAIL zero_beat1 got=%h exp=%h", {dif.out_last, dif.bus_out}, {1'b1, 32'd5}); end
      tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL zero_done got=%b exp=0", dif.busy); end
      do_start(32'd9, 32'd3);
      checks++; if (dif.div_zero !== 1'b0) begin failures++; $display("FAIL zero_clear got=%b exp=0", dif.div_zero); end
      repeat (4) tick();
      checks++; if (dif.bus_out !== 32'd3) begin failures++; $display("FAIL after_zero_lo got=%h exp=3", dif.bus_out); end
      tick();
      checks++; if ({dif.out_last, dif.bus_out} !== {1'b1, 32'd0}) begin failures++; $display("FAIL after_zero_hi got=%h exp=%h", {dif.out_last, dif.bus_out}, {1'b1, 32'd0}); end
      tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL after_zero_done got=%b exp=0", dif.busy); end
   endtask

   task automatic test_backpressure();
      dif.out_ready = 1'b0;
      do_start(32'd100, 32'd7);
      repeat (4) tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            dif.start = 1'b1;
            dif.ra_in = 32'd55;
            dif.rb_in = 32'd11;
         end
         tick();
         dif.start = 1'b0;
         checks++; if ({dif.out_valid, dif.out_last, dif.bus_out} !== {1'b1, 1'b0, 32'd14}) begin failures++; $display("FAIL bp_lo c%0d got=%h exp=%h", i, {dif.out_valid, dif.out_last, dif.bus_out}, {1'b1, 1'b0, 32'd14}); end
      end
      checks++; if ({dif.div_ra, dif.div_rb} !== {32'd100, 32'd7}) begin failures++; $display("FAIL bp_ops got=%h exp=%h", {dif.div_ra, dif.div_rb}, {32'd100, 32'd7}); end
      dif.out_ready = 1'b1;
      tick();
      dif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({dif.out_valid, dif.out_last, dif.bus_out} !== {1'b1, 1'b1, 32'd2}) begin failures++; $display("FAIL bp_hi c%0d got=%h exp=%h", i, {dif.out_valid, dif.out_last, dif.bus_out}, {1'b1, 1'b1, 32'd2}); end
      end
      dif.out_ready = 1'b1;
      tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL bp_done got=%b exp=0", dif.busy); end
   endtask

   task automatic test_reset_mid();
      dif.out_ready = 1'b1;
      do_start(32'd100, 32'd7);
      tick();
      clr = 1'b0;
      tick();
      clr = 1'b1;
      checks++; if ({dif.busy, dif.out_valid} !== 2'b00) begin failures++; $display("FAIL mid_rst_ctl got=%b exp=00", {dif.busy, dif.out_valid}); end
      checks++; if ({dif.hi_out, dif.lo_out} !== 64'd0) begin failures++; $display("FAIL mid_rst_hilo got=%h exp=0", {dif.hi_out, dif.lo_out}); end
      checks++; if ({dif.div_ra, dif.div_rb} !== 64'd0) begin failures++; $display("FAIL mid_rst_ops got=%h exp=0", {dif.div_ra, dif.div_rb}); end
      do_start(32'd20, 32'd6);
      repeat (4) tick();
      checks++; if (dif.bus_out !== 32'd3) begin failures++; $display("FAIL mid_rst_lo got=%h exp=3", dif.bus_out); end
      tick();
      checks++; if (dif.bus_out !== 32'd2) begin failures++; $display("FAIL mid_rst_hi got=%h exp=2", dif.bus_out); end
      tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", dif.busy); end
   endtask

   task automatic test_back_to_back();
      dif.out_ready = 1'b1;
      do_start(32'd100, 32'd7);
      repeat (4) tick();
      checks++; if (dif.bus_out !== 32'd14) begin failures++; $display("FAIL b2b_first_lo got=%h exp=%h", dif.bus_out, 32'd14); end
      tick();
      checks++; if (dif.bus_out !== 32'd2) begin failures++; $display("FAIL b2b_first_hi got=%h exp=2", dif.bus_out); end
      tick();
      dif.start = 1'b1;
      dif.ra_in = 32'hFFFF_FF9C;
      dif.rb_in = 32'd7;
      tick();
      checks++; if ({dif.busy, dif.div_ra} !== {1'b1, 32'hFFFF_FF9C}) begin failures++; $display("FAIL b2b_accept got=%h exp=%h", {dif.busy, dif.div_ra}, {1'b1, 32'hFFFF_FF9C}); end
      dif.ra_in = 32'd77;
      dif.rb_in = 32'd5;
      repeat (3) tick();
      checks++; if ({dif.div_ra, dif.div_rb} !== {32'hFFFF_FF9C, 32'd7}) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", {dif.div_ra, dif.div_rb}, {32'hFFFF_FF9C, 32'd7}); end
      tick();
      dif.start = 1'b0;
      checks++; if (dif.bus_out !== 32'hFFFF_FFF2) begin failures++; $display("FAIL b2b_second_lo got=%h exp=fffffff2", dif.bus_out); end
      tick();
      checks++; if ({dif.out_last, dif.bus_out} !== {1'b1, 32'd2}) begin failures++; $display("FAIL b2b_second_hi got=%h exp=%h", {dif.out_last, dif.bus_out}, {1'b1, 32'd2}); end
      tick();
      checks++; if (dif.busy !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b exp=0", dif.busy); end
   endtask

   initial begin
      dif.start     = 1'b0;
      dif.ra_in     = 32'd0;
      dif.rb_in     = 32'd0;
      dif.out_ready = 1'b0;
      test_reset();
      test_normal();
      test_negative();
      test_zero_divisor();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
